// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx
//   Byte-to-nibble physical transmitter for an HD44780-class character LCD
//   running in 4-bit mode. Takes command/data bytes over a valid/ready
//   handshake and drives DB7..DB4, E, RS and RW with setup, enable-pulse,
//   hold, inter-nibble gap and execution-time spacing.
//
// Optional feature macro: LCD_NIBBLE_TX_INIT_EN
//   defined   : after reset the block runs the power-up init sequence itself
//               and raises init_done (together with in_ready) when finished.
//   undefined : no init states, init_done is tied high.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  byte offered
//   in_ready   out  1  idle; byte accepted on in_valid && in_ready at a rising edge
//   in_data    in   8  byte to send, high nibble first
//   in_rs      in   1  0 = command, 1 = data
//   in_nib     in   1  send only in_data[7:4]
//   in_long    in   1  use T_LONG instead of T_EXEC for the execution wait
//   dataout    out  4  LCD DB7..DB4
//   control    out  3  {E, RS, RW}, RW always 0
//   done       out  1  one-cycle pulse when a transfer's execution wait ends
//   init_done  out  1  power-up init complete
module lcd_nibble_tx #(
  parameter int T_SU    = 2,
  parameter int T_PW    = 25,
  parameter int T_H     = 2,
  parameter int T_GAP   = 50,
  parameter int T_EXEC  = 2000,
  parameter int T_LONG  = 82000,
  parameter int T_PWRUP = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       in_nib,
  input  logic       in_long,
  output logic [3:0] dataout,
  output logic [2:0] control,
  output logic       done,
  output logic       init_done
);

  localparam int M1 = (T_SU > T_PW) ? T_SU : T_PW;
  localparam int M2 = (M1 > T_H) ? M1 : T_H;
  localparam int M3 = (M2 > T_GAP) ? M2 : T_GAP;
  localparam int M4 = (M3 > T_EXEC) ? M3 : T_EXEC;
  localparam int M5 = (M4 > T_LONG) ? M4 : T_LONG;
  localparam int M6 = (M5 > T_PWRUP) ? M5 : T_PWRUP;
  localparam int CW = $clog2(M6 + 1);

  typedef enum logic [3:0] {
    IDLE, SU_H, PW_H, HD_H, GAP, SU_L, PW_L, HD_L, WAIT
`ifdef LCD_NIBBLE_TX_INIT_EN
    , INIT_PWR
`endif
  } state_t;

  state_t        st, nst;
  logic [CW-1:0] cnt, ncnt;
  logic [3:0]    lo_q;
  logic          rs_q, nib_q, lng_q, e_q;
  logic          ld_ext, ld_int, ld, fin;
  logic [7:0]    src_byte;
  logic          src_rs, src_nib, src_lng;
  logic          wait_skip;
  logic [CW-1:0] wait_load;
  logic [3:0]    dataout_d;
  logic          e_d, rs_d, done_d, ready_d, init_done_d;

  // The cycle in which done is high is the last cycle of the execution wait,
  // so WAIT itself lasts one cycle less than the configured wait. A wait of
  // one cycle skips WAIT entirely.
  assign wait_skip = lng_q ? (T_LONG < 2) : (T_EXEC < 2);
  assign wait_load = lng_q ? CW'(T_LONG - 2) : CW'(T_EXEC - 2);

`ifdef LCD_NIBBLE_TX_INIT_EN
  logic [2:0] step_q, init_idx;
  logic [7:0] init_byte;

  assign init_idx = (st == INIT_PWR) ? 3'd0 : step_q + 3'd1;

  // Power-up table: three 0x3 nibbles, 0x2 nibble, then function set,
  // display on, entry mode and clear.
  always_comb begin
    case (init_idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = 8'h20;
      3'd4:             init_byte = 8'h28;
      3'd5:             init_byte = 8'h0C;
      3'd6:             init_byte = 8'h06;
      default:          init_byte = 8'h01;
    endcase
  end

  assign src_byte = ld_ext ? in_data : init_byte;
  assign src_rs   = ld_ext & in_rs;
  assign src_nib  = ld_ext ? in_nib : (init_idx < 3'd4);
  assign src_lng  = ld_ext ? in_long : ((init_idx == 3'd0) || (init_idx == 3'd7));
`else
  assign src_byte = in_data;
  assign src_rs   = in_rs;
  assign src_nib  = in_nib;
  assign src_lng  = in_long;
`endif

  assign ld = ld_ext | ld_int;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LCD_NIBBLE_TX_INIT_EN
      st        <= INIT_PWR;
      cnt       <= CW'(T_PWRUP - 1);
      init_done <= 1'b0;
      step_q    <= 3'd0;
`else
      st        <= IDLE;
      cnt       <= '0;
`endif
      lo_q      <= 4'h0;
      nib_q     <= 1'b0;
      lng_q     <= 1'b0;
      rs_q      <= 1'b0;
      e_q       <= 1'b0;
      dataout   <= 4'h0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      st        <= nst;
      cnt       <= ncnt;
      if (ld) begin
        lo_q  <= src_byte[3:0];
        nib_q <= src_nib;
        lng_q <= src_lng;
      end
      rs_q      <= rs_d;
      e_q       <= e_d;
      dataout   <= dataout_d;
      done      <= done_d;
      in_ready  <= ready_d;
`ifdef LCD_NIBBLE_TX_INIT_EN
      init_done <= init_done_d;
      if (ld_int) step_q <= init_idx;
`endif
    end
  end

`ifndef LCD_NIBBLE_TX_INIT_EN
  assign init_done = 1'b1;
`endif

  // Next state; the shared counter is reloaded whenever a state is entered
  always_comb begin
    nst    = st;
    ncnt   = cnt - CW'(1);
    ld_ext = 1'b0;
    ld_int = 1'b0;
    fin    = 1'b0;
    case (st)
      IDLE: begin
        ncnt = cnt;
        if (in_valid && in_ready) begin
          nst    = SU_H;
          ncnt   = CW'(T_SU - 1);
          ld_ext = 1'b1;
        end
      end
      SU_H: if (cnt == '0) begin nst = PW_H; ncnt = CW'(T_PW - 1); end
      PW_H: if (cnt == '0) begin nst = HD_H; ncnt = CW'(T_H - 1); end
      HD_H: if (cnt == '0) begin
        if (!nib_q) begin
          nst  = GAP;
          ncnt = CW'(T_GAP - 1);
        end else if (wait_skip) begin
          fin = 1'b1;
        end else begin
          nst  = WAIT;
          ncnt = wait_load;
        end
      end
      GAP:  if (cnt == '0) begin nst = SU_L; ncnt = CW'(T_SU - 1); end
      SU_L: if (cnt == '0) begin nst = PW_L; ncnt = CW'(T_PW - 1); end
      PW_L: if (cnt == '0) begin nst = HD_L; ncnt = CW'(T_H - 1); end
      HD_L: if (cnt == '0) begin
        if (wait_skip) begin
          fin = 1'b1;
        end else begin
          nst  = WAIT;
          ncnt = wait_load;
        end
      end
      WAIT: if (cnt == '0) fin = 1'b1;
`ifdef LCD_NIBBLE_TX_INIT_EN
      INIT_PWR: if (cnt == '0) begin
        nst    = SU_H;
        ncnt   = CW'(T_SU - 1);
        ld_int = 1'b1;
      end
`endif
      default: nst = IDLE;
    endcase
    if (fin) begin
      nst  = IDLE;
      ncnt = '0;
`ifdef LCD_NIBBLE_TX_INIT_EN
      // During init, a finished transfer chains straight into the next entry
      if (!init_done && (step_q != 3'd7)) begin
        nst    = SU_H;
        ncnt   = CW'(T_SU - 1);
        ld_int = 1'b1;
      end
`endif
    end
  end

  // Outputs are registered from the next state so pins change on state entry
  always_comb begin
    e_d       = (nst == PW_H) || (nst == PW_L);
    rs_d      = ld ? src_rs : rs_q;
    dataout_d = dataout;
    if (ld) begin
      dataout_d = src_byte[7:4];
    end else if ((nst == SU_L) && (st == GAP)) begin
      dataout_d = lo_q;
    end
`ifdef LCD_NIBBLE_TX_INIT_EN
    init_done_d = init_done | (fin && (step_q == 3'd7));
`else
    init_done_d = 1'b1;
`endif
    done_d  = fin && init_done;
    ready_d = (nst == IDLE) && init_done_d;
  end

  assign control = {e_q, rs_q, 1'b0};

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// tb_lcd_nibble_tx
//   Scoreboard bench for lcd_nibble_tx. The stimulus process pushes the
//   expected E pulses (nibble, RS, cycle) and done pulses for every byte it
//   hands over; a monitor process pops and compares whenever the DUT raises
//   E or done. Timing parameters are shrunk so the run stays short.
//   Build with LCD_NIBBLE_TX_INIT_EN to also cover the power-up sequence.
module tb_lcd_nibble_tx;

  localparam int T_SU    = 1;
  localparam int T_PW    = 2;
  localparam int T_H     = 1;
  localparam int T_GAP   = 3;
  localparam int T_EXEC  = 5;
  localparam int T_LONG  = 10;
  localparam int T_PWRUP = 20;
`ifdef LCD_NIBBLE_TX_INIT_EN
  localparam int INIT_RST = 0;
`else
  localparam int INIT_RST = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_rs;
  logic       in_nib;
  logic       in_long;
  logic [3:0] dataout;
  logic [2:0] control;
  logic       done;
  logic       init_done;

  typedef struct {
    bit         is_done;
    logic [3:0] nib;
    logic       rs;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  lcd_nibble_tx #(
    .T_SU(T_SU), .T_PW(T_PW), .T_H(T_H), .T_GAP(T_GAP),
    .T_EXEC(T_EXEC), .T_LONG(T_LONG), .T_PWRUP(T_PWRUP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_rs(in_rs),
    .in_nib(in_nib),
    .in_long(in_long),
    .dataout(dataout),
    .control(control),
    .done(done),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Offers one byte at the current negedge and queues its expected pulses.
  // r1/r2 are E rise cycles and dn the done cycle, counted from the accept
  // edge as cycle 0; r2 < 0 means a single-nibble transfer.
  task automatic applyStimulus(input logic [7:0] d, input logic rs, input logic nib,
                               input logic lng, input int r1, input logic [3:0] n1,
                               input int r2, input logic [3:0] n2, input int dn);
    int   g;
    int   a;
    exp_t it;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_rs    = rs;
    in_nib   = nib;
    in_long  = lng;
    a = cyc + 1;
    it.is_done = 1'b0; it.nib = n1; it.rs = rs; it.cyc = a + r1 - 1;
    exp_q.push_back(it);
    if (r2 >= 0) begin
      it.nib = n2; it.cyc = a + r2 - 1;
      exp_q.push_back(it);
    end
    it.is_done = 1'b1; it.nib = 4'h0; it.rs = 1'b0; it.cyc = a + dn - 1;
    exp_q.push_back(it);
    @(posedge clk);
    #1 checkOutput("ready_drop", in_ready, 0);
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    checkOutput("drain", exp_q.size(), 0);
  endtask

`ifdef LCD_NIBBLE_TX_INIT_EN
  task automatic expectInit();
    logic [3:0] seq [12];
    exp_t       it;
    seq = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
    for (int i = 0; i < 12; i++) begin
      it.is_done = 1'b0; it.nib = seq[i]; it.rs = 1'b0; it.cyc = -1;
      exp_q.push_back(it);
    end
  endtask
`endif

  // Called #2 after a negedge on which rst_n was released
  task automatic releaseCheck();
    int g;
    #1 checkOutput("rel_ready_low", in_ready, 0);
`ifdef LCD_NIBBLE_TX_INIT_EN
    expectInit();
    g = 0;
    while (!init_done && g < 2000) begin
      @(negedge clk);
      g++;
    end
    checkOutput("init_done_rise", init_done, 1);
    checkOutput("init_drain", exp_q.size(), 0);
`else
    g = 0;
    @(posedge clk);
    #1 checkOutput("rel_ready_high", in_ready, 1);
`endif
    @(negedge clk);
  endtask

  // Monitor: compares every E rise, E fall and done pulse against the queue
  initial begin : monitor
    bit         e_prev;
    bit         id_prev;
    int         rise_cyc;
    logic [3:0] rise_dat;
    exp_t       it;
    e_prev   = 1'b0;
    id_prev  = 1'b0;
    rise_cyc = 0;
    rise_dat = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e_prev  = 1'b0;
        id_prev = init_done;
      end else begin
        if (control[2] && !e_prev) begin
          rise_cyc = cyc;
          rise_dat = dataout;
          if (exp_q.size() == 0) begin
            checkOutput("e_pending", exp_q.size(), 1);
          end else if (exp_q[0].is_done) begin
            checkOutput("e_order", exp_q[0].is_done, 0);
          end else begin
            it = exp_q.pop_front();
            if (it.cyc >= 0) checkOutput("e_rise_cycle", cyc, it.cyc);
            checkOutput("e_nibble", dataout, it.nib);
            checkOutput("e_rs", control[1], it.rs);
          end
        end
        if (!control[2] && e_prev) begin
          checkOutput("e_width", cyc - rise_cyc, T_PW);
          checkOutput("e_hold_data", dataout, rise_dat);
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            checkOutput("done_pending", exp_q.size(), 1);
          end else if (!exp_q[0].is_done) begin
            checkOutput("done_order", exp_q[0].is_done, 1);
          end else begin
            it = exp_q.pop_front();
            checkOutput("done_cycle", cyc, it.cyc);
            checkOutput("done_ready", in_ready, 1);
          end
        end
        if (init_done && !id_prev) checkOutput("ready_with_init_done", in_ready, 1);
        e_prev  = control[2];
        id_prev = init_done;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int g;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_rs    = 1'b0;
    in_nib   = 1'b0;
    in_long  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_dataout", dataout, 0);
    checkOutput("rst_control", control, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_init_done", init_done, INIT_RST);
    #2 rst_n = 1'b1;
    releaseCheck();

    // Data byte 0x48, RS=1: E at 2 and 9, done at 16
    applyStimulus(8'h48, 1'b1, 1'b0, 1'b0, 2, 4'h4, 9, 4'h8, 16);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("rs_hold", control[1], 1);
    checkOutput("data_hold", dataout, 8);

    // Single nibble command 0x30: E at 2, done at 9
    applyStimulus(8'h30, 1'b0, 1'b1, 1'b0, 2, 4'h3, -1, 4'h0, 9);
    in_valid = 1'b0;
    waitDrain();

    // Long command 0x01 with in_valid held and inputs churning, then a
    // second long byte accepted on the done edge
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 2, 4'h0, 9, 4'h1, 21);
    g = 0;
    while (g < 60) begin
      @(negedge clk);
      if (in_ready) break;
      in_data = 8'($urandom);
      in_rs   = 1'($urandom);
      in_nib  = 1'($urandom);
      in_long = 1'($urandom);
      g++;
    end
    applyStimulus(8'h02, 1'b0, 1'b0, 1'b1, 2, 4'h0, 9, 4'h2, 21);
    in_valid = 1'b0;
    waitDrain();

    // Reset while E is high
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 2, 4'h5, 9, 4'hA, 16);
    in_valid = 1'b0;
    g = 0;
    while (!control[2] && g < 50) begin
      @(negedge clk);
      g++;
    end
    checkOutput("e_before_reset", control[2], 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_control", control, 0);
    checkOutput("midrst_dataout", dataout, 0);
    checkOutput("midrst_ready", in_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    releaseCheck();

    // Recovery byte after reset
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 2, 4'hA, 9, 4'h5, 16);
    in_valid = 1'b0;
    waitDrain();
    repeat (3) @(negedge clk);
    checkOutput("idle_done_low", done, 0);
    checkOutput("idle_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_tx.md
# lcd_nibble_tx

Byte-to-nibble physical transmitter for the HD44780-class character LCD in 4-bit mode. Accepts command/data bytes over a valid/ready handshake from the message/control logic. Drives the LCD pins (`dataout`, `control`) with correct setup, enable-pulse, hold, inter-nibble and execution-time spacing. Sits directly between the LCD text/command sequencer and the panel.

## Interface
- `T_SU`, 2: RS/data setup before E rise, clk cycles (≥1)
- `T_PW`, 25: E high width, cycles (≥1)
- `T_H`, 2: data/RS hold after E fall, cycles (≥1)
- `T_GAP`, 50: idle gap between high and low nibble, cycles (≥1)
- `T_EXEC`, 2000: post-byte execution wait, cycles (≥1)
- `T_LONG`, 82000: execution wait for clear/home, cycles (≥1)
- `T_PWRUP`, 750000: power-up delay, cycles (used only with init)
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  byte offered
- `in_ready`  out  1  block idle, byte accepted on `in_valid && in_ready` at a rising edge
- `in_data`  in  8  byte to send, high nibble first
- `in_rs`  in  1  0 = command, 1 = data
- `in_nib`  in  1  send only `in_data[7:4]` (init nibbles)
- `in_long`  in  1  use `T_LONG` instead of `T_EXEC`
- `dataout`  out  4  LCD DB7..DB4
- `control`  out  3  {E, RS, RW}: `[2]`=E, `[1]`=RS, `[0]`=RW (always 0)
- `done`  out  1  one-cycle pulse when a transfer's execution wait ends
- `init_done`  out  1  high once power-up init is complete

## Operation
- The FSM states are IDLE, SU_H, PW_H, HD_H, GAP, SU_L, PW_L, HD_L, WAIT, plus INIT_* states when the init feature is compiled in.
- On accept, `in_data`, `in_rs`, `in_nib` and `in_long` are latched. Later input changes are ignored until the next accept.
- SU_H: `dataout`=`in_data[7:4]`, RS=`in_rs`, E=0, for `T_SU` cycles.
- PW_H: E=1 for `T_PW` cycles.
- HD_H: E=0 with data held for `T_H` cycles.
- If `in_nib`=1, HD_H goes to WAIT. Otherwise the sequence is GAP (`T_GAP` cycles), then SU_L/PW_L/HD_L with `in_data[3:0]`, then WAIT.
- WAIT lasts `T_EXEC` cycles, or `T_LONG` when `in_long`=1. When it expires, `done` pulses for one cycle and the FSM returns to IDLE.
- `dataout` and RS hold their last values between transfers. E is high only in the PW states.
- `in_ready` is high only in IDLE with `init_done`=1. A new byte can be accepted on the same edge that `done` is asserted.
- A single down-counter, sized for the largest parameter, is reloaded on every state entry.
- Reset mid-transfer:
  - `rst_n` low immediately forces all outputs to their reset values and drops E, even mid-pulse.
  - The latched byte is discarded. There is no retry.

## Timing
- Reset values: `dataout`=0, `control`=3'b000, `in_ready`=0, `done`=0, `init_done`=0 (macro defined) or 1 (macro undefined).
- All outputs are registered.
- Accept edge = cycle 0. Bus data and RS change at cycle 1, and E rises at cycle 1+`T_SU`.
- Full byte latency, accept edge to `done` high = 2·(`T_SU`+`T_PW`+`T_H`)+`T_GAP`+`T_EXEC|T_LONG` cycles.
- Nibble latency = `T_SU`+`T_PW`+`T_H`+`T_EXEC|T_LONG` cycles.
- `in_ready` is low from cycle 1 and rises in the same cycle as `done`.
- Macro undefined: `in_ready` rises on the first edge after reset release.

## Configuration
- `LCD_NIBBLE_TX_INIT_EN` defined: after reset release the block runs the built-in power-up sequence, with `in_ready` held 0 throughout:
  - wait `T_PWRUP`
  - nibble 0x3 (WAIT `T_LONG`), nibble 0x3, nibble 0x3, nibble 0x2 (WAIT `T_EXEC` each)
  - bytes 0x28, 0x0C, 0x06 (`T_EXEC` each), then 0x01 (`T_LONG`), all with RS=0
  - `done` does not pulse for init transfers; `init_done` then rises together with `in_ready`
- `LCD_NIBBLE_TX_INIT_EN` undefined: no INIT states; `init_done` is tied 1 and upstream is responsible for panel initialisation.

## Test plan
Bench parameters: `T_SU`=1, `T_PW`=2, `T_H`=1, `T_GAP`=3, `T_EXEC`=5, `T_LONG`=10.
- Data byte, macro off: accept 0x48 with RS=1.
  - `dataout`=4'h4 with E high cycles 2–3, then `dataout`=4'h8 with E high cycles 9–10
  - RS=1 throughout; `done` at cycle 16, `in_ready` back to 1 at cycle 16
- Nibble command: `in_nib`=1, `in_data`=0x30, RS=0 -> a single E pulse with `dataout`=4'h3; `done` at cycle 9.
- Long command: 0x01 with `in_long`=1 -> `done` at cycle 21. `in_valid` held high with changing data during the transfer has no effect.
- Back-to-back: `in_valid` held high with two bytes -> second accept on the `done` edge, and exactly two `done` pulses 21 cycles apart.
- Reset mid-pulse: `rst_n` low while E=1 -> `control`=0 and `dataout`=0 immediately. After release, `in_ready`=1 after one edge (macro off).
- Init, macro on with `T_PWRUP`=20:
  - exactly 4 single-nibble E pulses (3,3,3,2), then 8 pulses forming 0x28, 0x0C, 0x06, 0x01
  - RS=0 throughout; `init_done` and `in_ready` rise together; no `done` pulses
